// File: rtl/exerion_rom_loader.sv
// Exerion ROM download receiver: decodes the HPS byte stream into per-region write
// strobes, packs sprite bytes into 16-bit words and gates the game reset on a valid image.
module exerion_rom_loader #(
    parameter logic [24:0] EXPECTED_LEN = 25'h10400,
    parameter logic [24:0] SPR_BASE     = 25'h0C000
) (
    input  logic        clkm_20MHZ,
    input  logic        RESET_n,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        dn_wait,
    output logic        cpu_we,
    output logic        sub_we,
    output logic        fg_we,
    output logic        bg_we,
    output logic        prom_we,
    output logic [14:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        spr_req,
    input  logic        spr_ack,
    output logic [11:0] spr_addr,
    output logic [15:0] spr_data,
    output logic [24:0] byte_count,
    output logic [7:0]  checksum,
    output logic        rom_ready,
    output logic        rom_err,
    output logic        core_reset_n
);

    localparam logic [24:0] SUB_BASE  = 25'h08000;
    localparam logic [24:0] FG_BASE   = 25'h0A000;
    localparam logic [24:0] FG_END    = 25'h0C000;
    localparam logic [24:0] BG_BASE   = 25'h0E000;
    localparam logic [24:0] PROM_BASE = 25'h10000;
    localparam logic [24:0] ROM_END   = 25'h10400;
    localparam logic [24:0] SPR_SIZE  = 25'h02000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HAVE_LO = 2'd1,
        S_PEND    = 2'd2
    } spr_state_t;

    spr_state_t  state_q, state_d, cur_state;
    logic        dl_q;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic [12:0] lo_addr_q, lo_addr_d;
    logic        spr_req_q, spr_req_d;
    logic        dn_wait_q, dn_wait_d;
    logic [11:0] spr_addr_q, spr_addr_d;
    logic [15:0] spr_data_q, spr_data_d;
    logic [14:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rom_data_q, rom_data_d;
    logic        cpu_we_q, cpu_we_d;
    logic        sub_we_q, sub_we_d;
    logic        fg_we_q, fg_we_d;
    logic        bg_we_q, bg_we_d;
    logic        prom_we_q, prom_we_d;
    logic [24:0] byte_count_q, byte_count_d;
    logic [7:0]  checksum_q, checksum_d;
    logic        oor_q, oor_d;
    logic        rom_ready_q, rom_ready_d;
    logic        rom_err_q, rom_err_d;
    logic        eval_pend_q, eval_pend_d;
    logic        core_reset_n_q, core_reset_n_d;

    logic        rise, fall, acc;
    logic        in_cpu, in_sub, in_fg, in_spr, in_bg, in_prom, in_oor, in_8bit;
    logic [14:0] base15;
    logic [12:0] spr_off;
    logic        fresh;
    logic        image_ok;

    assign rise = dn_download & ~dl_q;
    assign fall = ~dn_download & dl_q;
    assign acc  = dn_download & dn_wr & ~dn_wait_q;

    assign in_cpu  = (dn_addr < SUB_BASE);
    assign in_sub  = (dn_addr >= SUB_BASE) && (dn_addr < FG_BASE);
    assign in_fg   = (dn_addr >= FG_BASE) && (dn_addr < FG_END);
    assign in_spr  = (dn_addr >= SPR_BASE) && (dn_addr < SPR_BASE + SPR_SIZE);
    assign in_bg   = (dn_addr >= BG_BASE) && (dn_addr < PROM_BASE);
    assign in_prom = (dn_addr >= PROM_BASE) && (dn_addr < ROM_END);
    assign in_oor  = (dn_addr >= ROM_END);
    assign in_8bit = in_cpu | in_sub | in_fg | in_bg | in_prom;

    // The sprite region is 8 KB, so the low 13 bits give the local offset for any base.
    assign spr_off = dn_addr[12:0] - SPR_BASE[12:0];

    always_comb begin
        base15 = 15'h0000;
        if (in_sub) begin
            base15 = SUB_BASE[14:0];
        end else if (in_fg) begin
            base15 = FG_BASE[14:0];
        end else if (in_bg) begin
            base15 = BG_BASE[14:0];
        end else if (in_prom) begin
            base15 = PROM_BASE[14:0];
        end
    end

    always_comb begin
        // A new download restarts everything, even a handshake left hanging.
        cur_state      = rise ? S_IDLE : state_q;
        state_d        = cur_state;
        lo_byte_d      = lo_byte_q;
        lo_addr_d      = lo_addr_q;
        spr_req_d      = rise ? 1'b0 : spr_req_q;
        dn_wait_d      = rise ? 1'b0 : dn_wait_q;
        spr_addr_d     = spr_addr_q;
        spr_data_d     = spr_data_q;
        rom_addr_d     = rom_addr_q;
        rom_data_d     = rom_data_q;
        cpu_we_d       = 1'b0;
        sub_we_d       = 1'b0;
        fg_we_d        = 1'b0;
        bg_we_d        = 1'b0;
        prom_we_d      = 1'b0;
        byte_count_d   = rise ? 25'd0 : byte_count_q;
        checksum_d     = rise ? 8'd0 : checksum_q;
        oor_d          = rise ? 1'b0 : oor_q;
        rom_ready_d    = rise ? 1'b0 : rom_ready_q;
        rom_err_d      = rise ? 1'b0 : rom_err_q;
        eval_pend_d    = rise ? 1'b0 : eval_pend_q;
        core_reset_n_d = rise ? 1'b0 : rom_ready_q;
        fresh          = 1'b0;
        image_ok       = (byte_count_q == EXPECTED_LEN) && !oor_q;

        if (acc) begin
            byte_count_d = byte_count_d + 25'd1;
            checksum_d   = checksum_d + dn_data;
            if (in_8bit) begin
                rom_addr_d = dn_addr[14:0] - base15;
                rom_data_d = dn_data;
            end
            cpu_we_d  = in_cpu;
            sub_we_d  = in_sub;
            fg_we_d   = in_fg;
            bg_we_d   = in_bg;
            prom_we_d = in_prom;
            if (in_oor) begin
                oor_d = 1'b1;
            end
            if (in_spr) begin
                if (cur_state == S_HAVE_LO) begin
                    if (spr_off == lo_addr_q + 13'd1) begin
                        spr_data_d = {dn_data, lo_byte_q};
                        spr_addr_d = spr_off[12:1];
                        spr_req_d  = 1'b1;
                        dn_wait_d  = 1'b1;
                        state_d    = S_PEND;
                    end else begin
                        oor_d = 1'b1;
                        fresh = 1'b1;
                    end
                end else begin
                    fresh = 1'b1;
                end
            end
        end

        // A byte that opens a new sprite word must sit on an even address.
        if (fresh) begin
            if (!spr_off[0]) begin
                lo_byte_d = dn_data;
                lo_addr_d = spr_off;
                state_d   = S_HAVE_LO;
            end else begin
                oor_d   = 1'b1;
                state_d = S_IDLE;
            end
        end

        if ((cur_state == S_PEND) && spr_ack) begin
            spr_req_d = 1'b0;
            dn_wait_d = 1'b0;
            state_d   = S_IDLE;
        end

        if (fall) begin
            eval_pend_d = 1'b1;
            if (cur_state == S_HAVE_LO) begin
                oor_d   = 1'b1;
                state_d = S_IDLE;
            end
        end

        // Judge the image only once any outstanding sprite word has been handed off.
        if (eval_pend_q && !rise && (state_q == S_IDLE)) begin
            rom_ready_d = image_ok;
            rom_err_d   = !image_ok;
            eval_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clkm_20MHZ) begin
        if (!RESET_n) begin
            state_q        <= S_IDLE;
            dl_q           <= 1'b0;
            lo_byte_q      <= 8'd0;
            lo_addr_q      <= 13'd0;
            spr_req_q      <= 1'b0;
            dn_wait_q      <= 1'b0;
            spr_addr_q     <= 12'd0;
            spr_data_q     <= 16'd0;
            rom_addr_q     <= 15'd0;
            rom_data_q     <= 8'd0;
            cpu_we_q       <= 1'b0;
            sub_we_q       <= 1'b0;
            fg_we_q        <= 1'b0;
            bg_we_q        <= 1'b0;
            prom_we_q      <= 1'b0;
            byte_count_q   <= 25'd0;
            checksum_q     <= 8'd0;
            oor_q          <= 1'b0;
            rom_ready_q    <= 1'b0;
            rom_err_q      <= 1'b0;
            eval_pend_q    <= 1'b0;
            core_reset_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dl_q           <= dn_download;
            lo_byte_q      <= lo_byte_d;
            lo_addr_q      <= lo_addr_d;
            spr_req_q      <= spr_req_d;
            dn_wait_q      <= dn_wait_d;
            spr_addr_q     <= spr_addr_d;
            spr_data_q     <= spr_data_d;
            rom_addr_q     <= rom_addr_d;
            rom_data_q     <= rom_data_d;
            cpu_we_q       <= cpu_we_d;
            sub_we_q       <= sub_we_d;
            fg_we_q        <= fg_we_d;
            bg_we_q        <= bg_we_d;
            prom_we_q      <= prom_we_d;
            byte_count_q   <= byte_count_d;
            checksum_q     <= checksum_d;
            oor_q          <= oor_d;
            rom_ready_q    <= rom_ready_d;
            rom_err_q      <= rom_err_d;
            eval_pend_q    <= eval_pend_d;
            core_reset_n_q <= core_reset_n_d;
        end
    end

    assign dn_wait      = dn_wait_q;
    assign cpu_we       = cpu_we_q;
    assign sub_we       = sub_we_q;
    assign fg_we        = fg_we_q;
    assign bg_we        = bg_we_q;
    assign prom_we      = prom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_data     = rom_data_q;
    assign spr_req      = spr_req_q;
    assign spr_addr     = spr_addr_q;
    assign spr_data     = spr_data_q;
    assign byte_count   = byte_count_q;
    assign checksum     = checksum_q;
    assign rom_ready    = rom_ready_q;
    assign rom_err      = rom_err_q;
    assign core_reset_n = core_reset_n_q;

endmodule

// File: doc/exerion_rom_loader.md
Name: exerion_rom_loader

Overview:
- Receiving end of the HPS ROM download stream (ioctl index 0) inside the Exerion core.
- Decodes each downloaded byte into one of six ROM regions and issues per-region write strobes with region-local addresses.
- Packs the sprite region into 16-bit words behind a req/ack handshake, back-pressuring the HPS through dn_wait.
- Tracks byte count and checksum. Holds the game in reset until a complete image has arrived.

Parameters:
- EXPECTED_LEN, 25'h10400, total image bytes required for a valid load.
- SPR_BASE, 25'h0C000, first byte address of the 16-bit packed sprite region (region is 8 KB).

Ports:
- clkm_20MHZ  in  1  system clock; all logic on rising edge.
- RESET_n  in  1  synchronous active-low reset.
- dn_download  in  1  high while the HPS download of index 0 is active.
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  25  byte address of dn_data.
- dn_data  in  8  download byte.
- dn_wait  out  1  back-pressure to HPS; no dn_wr accepted while high.
- cpu_we  out  1  main CPU ROM write strobe, 0x00000-0x07FFF.
- sub_we  out  1  sub CPU ROM write strobe, 0x08000-0x09FFF.
- fg_we  out  1  foreground char ROM write strobe, 0x0A000-0x0BFFF.
- bg_we  out  1  background ROM write strobe, 0x0E000-0x0FFFF.
- prom_we  out  1  colour/lookup PROM write strobe, 0x10000-0x103FF.
- rom_addr  out  15  region-local byte address for the 8-bit regions.
- rom_data  out  8  byte for the 8-bit regions.
- spr_req  out  1  sprite word write request; held until ack.
- spr_ack  in  1  sprite memory accepted the word.
- spr_addr  out  12  sprite word address (local byte address >> 1).
- spr_data  out  16  {odd byte, even byte}.
- byte_count  out  25  bytes accepted this download.
- checksum  out  8  mod-256 sum of accepted bytes.
- rom_ready  out  1  image complete and valid.
- rom_err  out  1  last download was the wrong length or out of range.
- core_reset_n  out  1  active-low reset for the game core.

Behaviour:
- Reset values:
  - All strobes, spr_req, dn_wait, rom_ready, rom_err = 0.
  - byte_count = 0, checksum = 0.
  - rom_addr, rom_data, spr_addr, spr_data = 0.
  - core_reset_n = 0.
  - FSM in IDLE.
- 8-bit regions (address decode on dn_addr):
  - dn_wr registers rom_addr = dn_addr minus region base, and rom_data = dn_data.
  - The matching *_we pulses exactly one cycle, one cycle after dn_wr.
  - At most one *_we is high at a time.
  - 0x0C000-0x0DFFF drives no 8-bit strobe.
  - Addresses at or above 0x10400 produce no strobe and set an out_of_range flag.
- Sprite FSM:
  - IDLE: on a sprite-region dn_wr with even address, latch the byte as the low byte and go to HAVE_LO.
    - An odd address arriving in IDLE sets out_of_range and is discarded.
  - HAVE_LO: on the next sprite dn_wr, set spr_data = {dn_data, lo}, spr_addr = (dn_addr - SPR_BASE) >> 1, spr_req = 1, dn_wait = 1; go to PEND.
    - If that next byte's address is not lo_addr+1, discard lo, set out_of_range, and treat the new byte as a fresh IDLE-entry byte.
  - PEND: hold spr_req, spr_addr, spr_data and dn_wait stable. On the first cycle spr_ack = 1, drop spr_req and dn_wait on the next edge and go to IDLE.
  - spr_ack outside PEND is ignored.
- Counters:
  - Every accepted dn_wr (any address) increments byte_count and adds dn_data to checksum, wrapping mod 256.
- Download edges:
  - Rising edge of dn_download:
    - clear byte_count, checksum, rom_ready, rom_err, out_of_range;
    - drop core_reset_n;
    - force the FSM to IDLE and clear spr_req/dn_wait, even mid-PEND.
  - Falling edge of dn_download:
    - if FSM is PEND, finish the handshake first and evaluate one cycle after it returns to IDLE;
    - if FSM is HAVE_LO, the dangling byte counts as an error.
    - Evaluation: rom_ready = (byte_count == EXPECTED_LEN) and no error; rom_err = its complement.
- core_reset_n = rom_ready. It is registered, so the game leaves reset exactly one cycle after rom_ready rises.
- dn_wr while dn_download = 0 is ignored entirely.
- A RESET_n assertion mid-download returns all state to reset values. A fresh download is then required.

Test Plan:
- 8-bit decode: download with dn_wr at 0x08005, data 0xA5 -> sub_we pulses one cycle after dn_wr, rom_addr = 0x0005, rom_data = 0xA5, no other strobe.
- Sprite pack: bytes 0x34 @0x0C010, then 0x12 @0x0C011, ack after 3 cycles -> spr_req and dn_wait high 3 cycles, spr_addr = 0x008, spr_data = 0x1234; FSM back to IDLE.
- Full image: 0x10400 bytes of value 0x01, ack same-cycle each time -> byte_count = 0x10400, checksum = 0x00, rom_ready = 1, rom_err = 0, core_reset_n rises one cycle later.
- Short image: 0x10000 bytes, then dn_download falls -> rom_ready = 0, rom_err = 1, core_reset_n stays 0.
- Odd-length sprite tail: last byte @0x0C000 only, dn_download falls -> rom_err = 1.
- Restart mid-PEND: spr_req held, no ack, dn_download toggles low then high -> on the rising edge spr_req = 0, dn_wait = 0, byte_count = 0, checksum = 0.
- Reset mid-download: RESET_n low for one cycle during a download -> all outputs return to reset values.
